// File: rtl/ddr_cmd_arbiter.sv
// Round-robin arbiter that shares one DDR server command port between N clients.
// Read responses are routed back to their issuer through an in-order tag FIFO.
module ddr_cmd_arbiter #(
  parameter int N_CLIENTS = 2,
  parameter int TAG_DEPTH = 4,
  parameter int DATA_W    = 256
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_CLIENTS-1:0]   i_command,
  input  logic [N_CLIENTS-1:0]   i_writeElseRead,
  input  logic [2*N_CLIENTS-1:0] i_commandSize,
  input  logic [15*N_CLIENTS-1:0] i_targetAddr,
  input  logic [3*N_CLIENTS-1:0] i_subAddr,
  output logic [N_CLIENTS-1:0]   o_busy,
  output logic [N_CLIENTS-1:0]   o_dataValid,
  output logic [DATA_W-1:0]      o_readData,
  input  logic                   i_serverBusy,
  input  logic                   i_dataValid,
  input  logic [DATA_W-1:0]      i_readData,
  output logic                   o_command,
  output logic                   o_writeElseRead,
  output logic [1:0]             o_commandSize,
  output logic [14:0]            o_targetAddr,
  output logic [2:0]             o_subAddr,
  output logic                   o_error
);

  localparam int CW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [PW:0] TAG_FULL = (PW + 1)'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [14:0] addr;
    logic [2:0]  sub;
  } cmd_t;

  localparam cmd_t CMD_RST = '{wr: 1'b1, size: 2'b00, addr: 15'd0, sub: 3'd0};

  state_e                 state_q, state_d;
  logic [N_CLIENTS-1:0]   pending_q, pending_d;
  cmd_t                   slot_q [N_CLIENTS];
  cmd_t                   slot_d [N_CLIENTS];
  logic [CW-1:0]          last_grant_q, last_grant_d;
  cmd_t                   cmd_q, cmd_d;
  logic                   command_q, command_d;
  logic [N_CLIENTS-1:0]   data_valid_q, data_valid_d;
  logic [DATA_W-1:0]      read_data_q, read_data_d;
  logic                   error_q, error_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW:0]            tag_count_q, tag_count_d;
  logic [CW-1:0]          tag_mem [TAG_DEPTH];

  logic [N_CLIENTS-1:0]   eligible;
  logic                   grant_found;
  logic [CW-1:0]          grant_idx;
  logic                   push;
  logic                   pop;

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    int idx;
    state_d      = state_q;
    pending_d    = pending_q;
    slot_d       = slot_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    command_d    = 1'b0;
    data_valid_d = '0;
    read_data_d  = read_data_q;
    error_d      = error_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tag_count_d  = tag_count_q;
    eligible     = '0;
    grant_found  = 1'b0;
    grant_idx    = '0;
    push         = 1'b0;
    pop          = 1'b0;
    idx          = 0;

    for (int k = 0; k < N_CLIENTS; k++) begin
      if (i_command[k] && !pending_q[k]) begin
        pending_d[k] = 1'b1;
        slot_d[k] = '{wr:   i_writeElseRead[k],
                      size: i_commandSize[2*k +: 2],
                      addr: i_targetAddr[15*k +: 15],
                      sub:  i_subAddr[3*k +: 3]};
      end
      // Reads need a free tag; writes never wait on the FIFO.
      eligible[k] = pending_q[k] && (slot_q[k].wr || (tag_count_q < TAG_FULL));
    end

    for (int i = 0; i < N_CLIENTS; i++) begin
      idx = (int'(last_grant_q) + 1 + i) % N_CLIENTS;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = CW'(idx);
      end
    end

    case (state_q)
      IDLE: begin
        if (!i_serverBusy && grant_found) begin
          cmd_d                = slot_q[grant_idx];
          command_d            = 1'b1;
          pending_d[grant_idx] = 1'b0;
          last_grant_d         = grant_idx;
          push                 = !slot_q[grant_idx].wr;
          state_d              = ISSUE;
        end
      end
      ISSUE:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (i_dataValid) begin
      if (tag_count_q != '0) begin
        pop                              = 1'b1;
        data_valid_d[tag_mem[rd_ptr_q]] = 1'b1;
        read_data_d                      = i_readData;
      end else begin
        error_d = 1'b1;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   tag_count_d = tag_count_q + 1'b1;
      2'b01:   tag_count_d = tag_count_q - 1'b1;
      default: tag_count_d = tag_count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      for (int k = 0; k < N_CLIENTS; k++) slot_q[k] <= '0;
      last_grant_q <= CW'(N_CLIENTS - 1);
      cmd_q        <= CMD_RST;
      command_q    <= 1'b0;
      data_valid_q <= '0;
      read_data_q  <= '0;
      error_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      slot_q       <= slot_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      command_q    <= command_d;
      data_valid_q <= data_valid_d;
      read_data_q  <= read_data_d;
      error_q      <= error_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tag_count_q  <= tag_count_d;
    end
  end

  // NOTE: tag storage is not reset; entries are only read behind a non-zero count, so stale contents are harmless.
  always_ff @(posedge i_clk) begin
    if (push) tag_mem[wr_ptr_q] <= grant_idx;
  end

  assign o_busy          = pending_q;
  assign o_dataValid     = data_valid_q;
  assign o_readData      = read_data_q;
  assign o_command       = command_q;
  assign o_writeElseRead = cmd_q.wr;
  assign o_commandSize   = cmd_q.size;
  assign o_targetAddr    = cmd_q.addr;
  assign o_subAddr       = cmd_q.sub;
  assign o_error         = error_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Scoreboard bench for ddr_cmd_arbiter: expected server commands and read
// responses are queued as stimulus is driven and popped as the DUT produces them.
module tb_ddr_cmd_arbiter;

  localparam int N  = 2;
  localparam int DW = 256;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [14:0] addr;
    logic [2:0]  sub;
  } cmd_t;

  typedef struct packed {
    logic [N-1:0]  dv;
    logic [DW-1:0] data;
  } resp_t;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [N-1:0]    i_command;
  logic [N-1:0]    i_writeElseRead;
  logic [2*N-1:0]  i_commandSize;
  logic [15*N-1:0] i_targetAddr;
  logic [3*N-1:0]  i_subAddr;
  logic [N-1:0]    o_busy;
  logic [N-1:0]    o_dataValid;
  logic [DW-1:0]   o_readData;
  logic            i_serverBusy;
  logic            i_dataValid;
  logic [DW-1:0]   i_readData;
  logic            o_command;
  logic            o_writeElseRead;
  logic [1:0]      o_commandSize;
  logic [14:0]     o_targetAddr;
  logic [2:0]      o_subAddr;
  logic            o_error;

  ddr_cmd_arbiter #(.N_CLIENTS(N), .TAG_DEPTH(4), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_command(i_command), .i_writeElseRead(i_writeElseRead),
    .i_commandSize(i_commandSize), .i_targetAddr(i_targetAddr), .i_subAddr(i_subAddr),
    .o_busy(o_busy), .o_dataValid(o_dataValid), .o_readData(o_readData),
    .i_serverBusy(i_serverBusy), .i_dataValid(i_dataValid), .i_readData(i_readData),
    .o_command(o_command), .o_writeElseRead(o_writeElseRead),
    .o_commandSize(o_commandSize), .o_targetAddr(o_targetAddr), .o_subAddr(o_subAddr),
    .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  int cycle = 0;
  always @(posedge i_clk) cycle <= cycle + 1;

  int    checks   = 0;
  int    failures = 0;
  cmd_t  exp_cmd[$];
  resp_t exp_resp[$];

  function automatic cmd_t obs_cmd();
    return {o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr};
  endfunction

  function automatic resp_t obs_resp();
    return {o_dataValid, o_readData};
  endfunction

  task automatic drive(input int k, input logic we, input logic [1:0] sz,
                       input logic [14:0] a, input logic [2:0] s);
    i_command[k]          = 1'b1;
    i_writeElseRead[k]    = we;
    i_commandSize[2*k+:2] = sz;
    i_targetAddr[15*k+:15] = a;
    i_subAddr[3*k+:3]     = s;
  endtask

  task automatic release_cmds();
    @(negedge i_clk);
    i_command = '0;
  endtask

  task automatic wait_cmd(input int budget, output bit seen, output cmd_t obs, output int stamp);
    seen  = 1'b0;
    obs   = '0;
    stamp = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge i_clk);
      if (o_command) begin
        seen  = 1'b1;
        obs   = obs_cmd();
        stamp = cycle;
        return;
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_command = '0; i_writeElseRead = '0; i_commandSize = '0;
    i_targetAddr = '0; i_subAddr = '0; i_serverBusy = 1'b0; i_dataValid = 1'b0; i_readData = '0;
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_command, o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr} !== {1'b0, 1'b1, 20'd0}) begin
      failures++;
      $display("FAIL reset_server_outs: got cmd=%b we=%b size=%b addr=%h sub=%h required cmd=0 we=1 rest 0",
               o_command, o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr);
    end
    checks++;
    if ({o_busy, o_dataValid, o_error} !== '0 || o_readData !== '0) begin
      failures++;
      $display("FAIL reset_client_outs: got busy=%b dv=%b err=%b rdata=%h required all 0",
               o_busy, o_dataValid, o_error, o_readData);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_single_write();
    cmd_t e;
    drive(0, 1'b1, 2'b10, 15'd0, 3'd0);
    exp_cmd.push_back('{we: 1'b1, size: 2'b10, addr: 15'd0, sub: 3'd0});
    release_cmds();
    checks++;
    if (o_busy !== 2'b01 || o_command !== 1'b0) begin
      failures++;
      $display("FAIL single_pending: got busy=%b cmd=%b required busy=01 cmd=0", o_busy, o_command);
    end
    @(negedge i_clk);
    e = exp_cmd.pop_front();
    checks++;
    if (o_command !== 1'b1 || obs_cmd() !== e || o_busy !== 2'b00) begin
      failures++;
      $display("FAIL single_issue: got cmd=%b fields=%h busy=%b required cmd=1 fields=%h busy=00",
               o_command, obs_cmd(), o_busy, e);
    end
    @(negedge i_clk);
    checks++;
    if (o_command !== 1'b0) begin
      failures++;
      $display("FAIL single_one_cycle: got cmd=%b required 0", o_command);
    end
    repeat (3) @(negedge i_clk);
  endtask

  // Both clients request together; bench tracks the round-robin pointer itself.
  task automatic test_contention(inout int model_last);
    cmd_t c [2];
    cmd_t e, obs;
    bit   seen;
    int   s0, s1, first;
    for (int r = 0; r < 3; r++) begin
      c[0] = '{we: 1'b1, size: 2'b01, addr: 15'(10 + r), sub: 3'(r)};
      c[1] = '{we: 1'b1, size: 2'b00, addr: 15'(20 + r), sub: 3'(r + 1)};
      drive(0, c[0].we, c[0].size, c[0].addr, c[0].sub);
      drive(1, c[1].we, c[1].size, c[1].addr, c[1].sub);
      first = (model_last == 0) ? 1 : 0;
      exp_cmd.push_back(c[first]);
      exp_cmd.push_back(c[1 - first]);
      model_last = 1 - first;
      release_cmds();
      wait_cmd(8, seen, obs, s0);
      e = exp_cmd.pop_front();
      checks++;
      if (!seen || obs !== e) begin
        failures++;
        $display("FAIL contention_first r=%0d: got seen=%b fields=%h required fields=%h", r, seen, obs, e);
      end
      @(negedge i_clk);
      checks++;
      if (o_command !== 1'b0) begin
        failures++;
        $display("FAIL contention_back_to_back r=%0d: got cmd=%b required 0", r, o_command);
      end
      wait_cmd(8, seen, obs, s1);
      e = exp_cmd.pop_front();
      checks++;
      if (!seen || obs !== e || (s1 - s0) != 3) begin
        failures++;
        $display("FAIL contention_second r=%0d: got seen=%b fields=%h spacing=%0d required fields=%h spacing=3",
                 r, seen, obs, s1 - s0, e);
      end
      repeat (3) @(negedge i_clk);
    end
  endtask

  task automatic test_server_busy(inout int model_last);
    cmd_t e;
    int   bad;
    i_serverBusy = 1'b1;
    drive(1, 1'b1, 2'b10, 15'h1abc, 3'd5);
    exp_cmd.push_back('{we: 1'b1, size: 2'b10, addr: 15'h1abc, sub: 3'd5});
    release_cmds();
    bad = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_command !== 1'b0 || o_busy[1] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_hold: got %0d bad cycles required 0", bad);
    end
    i_serverBusy = 1'b0;
    @(negedge i_clk);
    e = exp_cmd.pop_front();
    model_last = 1;
    checks++;
    if (o_command !== 1'b1 || obs_cmd() !== e) begin
      failures++;
      $display("FAIL busy_release: got cmd=%b fields=%h required cmd=1 fields=%h", o_command, obs_cmd(), e);
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_read_routing(inout int model_last);
    cmd_t  e, obs;
    resp_t er;
    bit    seen;
    int    st;
    drive(1, 1'b0, 2'b10, 15'd3, 3'd0);
    exp_cmd.push_back('{we: 1'b0, size: 2'b10, addr: 15'd3, sub: 3'd0});
    release_cmds();
    wait_cmd(8, seen, obs, st);
    e = exp_cmd.pop_front();
    checks++;
    if (!seen || obs !== e) begin
      failures++;
      $display("FAIL read_cmd_c1: got seen=%b fields=%h required %h", seen, obs, e);
    end
    exp_resp.push_back('{dv: 2'b10, data: {32{8'haa}}});
    drive(0, 1'b0, 2'b10, 15'd1, 3'd0);
    exp_cmd.push_back('{we: 1'b0, size: 2'b10, addr: 15'd1, sub: 3'd0});
    release_cmds();
    wait_cmd(8, seen, obs, st);
    e = exp_cmd.pop_front();
    checks++;
    if (!seen || obs !== e) begin
      failures++;
      $display("FAIL read_cmd_c0: got seen=%b fields=%h required %h", seen, obs, e);
    end
    exp_resp.push_back('{dv: 2'b01, data: {32{8'h55}}});
    model_last = 0;
    repeat (3) @(negedge i_clk);
    i_dataValid = 1'b1;
    i_readData  = {32{8'haa}};
    @(negedge i_clk);
    i_readData  = {32{8'h55}};
    er = exp_resp.pop_front();
    checks++;
    if (obs_resp() !== er) begin
      failures++;
      $display("FAIL read_resp0: got dv=%b data=%h required dv=%b data=%h", o_dataValid, o_readData, er.dv, er.data);
    end
    @(negedge i_clk);
    i_dataValid = 1'b0;
    i_readData  = '0;
    er = exp_resp.pop_front();
    checks++;
    if (obs_resp() !== er) begin
      failures++;
      $display("FAIL read_resp1: got dv=%b data=%h required dv=%b data=%h", o_dataValid, o_readData, er.dv, er.data);
    end
    @(negedge i_clk);
    checks++;
    if (o_dataValid !== 2'b00 || o_readData !== {32{8'h55}}) begin
      failures++;
      $display("FAIL read_hold: got dv=%b data=%h required dv=00 data held", o_dataValid, o_readData);
    end
  endtask

  task automatic test_tag_full(inout int model_last);
    cmd_t  e, obs;
    resp_t er;
    bit    seen;
    int    st, bad;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 2'b00, 15'(40 + i), 3'd0);
      exp_cmd.push_back('{we: 1'b0, size: 2'b00, addr: 15'(40 + i), sub: 3'd0});
      release_cmds();
      wait_cmd(8, seen, obs, st);
      e = exp_cmd.pop_front();
      checks++;
      if (!seen || obs !== e) begin
        failures++;
        $display("FAIL fill_read%0d: got seen=%b fields=%h required %h", i, seen, obs, e);
      end
      exp_resp.push_back('{dv: 2'b01, data: {8{32'(32'hc0de0000 + i)}}});
    end
    model_last = 0;
    repeat (3) @(negedge i_clk);
    drive(0, 1'b0, 2'b01, 15'd50, 3'd1);
    drive(1, 1'b1, 2'b10, 15'd60, 3'd2);
    exp_cmd.push_back('{we: 1'b1, size: 2'b10, addr: 15'd60, sub: 3'd2});
    release_cmds();
    wait_cmd(8, seen, obs, st);
    e = exp_cmd.pop_front();
    model_last = 1;
    checks++;
    if (!seen || obs !== e) begin
      failures++;
      $display("FAIL full_write_passes: got seen=%b fields=%h required %h", seen, obs, e);
    end
    bad = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (o_command !== 1'b0 || o_busy[0] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL full_read_held: got %0d bad cycles required 0", bad);
    end
    exp_cmd.push_back('{we: 1'b0, size: 2'b01, addr: 15'd50, sub: 3'd1});
    i_dataValid = 1'b1;
    i_readData  = exp_resp[0].data;
    @(negedge i_clk);
    i_dataValid = 1'b0;
    er = exp_resp.pop_front();
    checks++;
    if (obs_resp() !== er) begin
      failures++;
      $display("FAIL full_resp: got dv=%b data=%h required dv=%b data=%h", o_dataValid, o_readData, er.dv, er.data);
    end
    wait_cmd(8, seen, obs, st);
    e = exp_cmd.pop_front();
    model_last = 0;
    checks++;
    if (!seen || obs !== e) begin
      failures++;
      $display("FAIL full_read_released: got seen=%b fields=%h required %h", seen, obs, e);
    end
    exp_resp.push_back('{dv: 2'b01, data: {8{32'h0badf00d}}});
    repeat (3) @(negedge i_clk);
    for (int j = 0; j < 4; j++) begin
      i_dataValid = 1'b1;
      i_readData  = exp_resp[0].data;
      @(negedge i_clk);
      er = exp_resp.pop_front();
      checks++;
      if (obs_resp() !== er) begin
        failures++;
        $display("FAIL drain%0d: got dv=%b data=%h required dv=%b data=%h", j, o_dataValid, o_readData, er.dv, er.data);
      end
    end
    i_dataValid = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_error_reset(inout int model_last);
    cmd_t e, obs;
    bit   seen;
    int   st;
    i_dataValid = 1'b1;
    @(negedge i_clk);
    i_dataValid = 1'b0;
    checks++;
    if (o_dataValid !== 2'b00 || o_error !== 1'b1) begin
      failures++;
      $display("FAIL err_empty_resp: got dv=%b err=%b required dv=00 err=1", o_dataValid, o_error);
    end
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_error !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: got %b required 1", o_error);
    end
    drive(0, 1'b1, 2'b00, 15'd70, 3'd0);
    drive(1, 1'b1, 2'b00, 15'd71, 3'd0);
    release_cmds();
    wait_cmd(8, seen, obs, st);
    checks++;
    if (!seen || o_busy !== ((model_last == 0) ? 2'b01 : 2'b10)) begin
      failures++;
      $display("FAIL issue_before_rst: got seen=%b busy=%b", seen, o_busy);
    end
    #1 i_rst = 1'b0;
    #1;
    checks++;
    if (o_command !== 1'b0 || o_busy !== 2'b00 || o_error !== 1'b0 || o_writeElseRead !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got cmd=%b busy=%b err=%b we=%b required 0 00 0 1",
               o_command, o_busy, o_error, o_writeElseRead);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    drive(0, 1'b1, 2'b01, 15'd80, 3'd3);
    drive(1, 1'b0, 2'b10, 15'd81, 3'd4);
    exp_cmd.push_back('{we: 1'b1, size: 2'b01, addr: 15'd80, sub: 3'd3});
    exp_cmd.push_back('{we: 1'b0, size: 2'b10, addr: 15'd81, sub: 3'd4});
    model_last = 1;
    release_cmds();
    for (int i = 0; i < 2; i++) begin
      wait_cmd(8, seen, obs, st);
      e = exp_cmd.pop_front();
      checks++;
      if (!seen || obs !== e) begin
        failures++;
        $display("FAIL post_reset_grant%0d: got seen=%b fields=%h required %h", i, seen, obs, e);
      end
    end
    repeat (3) @(negedge i_clk);
  endtask

  initial begin
    int model_last;
    model_last = N - 1;
    test_reset();
    test_single_write();
    model_last = 0;
    test_contention(model_last);
    test_server_busy(model_last);
    test_read_routing(model_last);
    test_tag_full(model_last);
    test_error_reset(model_last);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
